// File: rtl/mod_gpio2.sv
// mod_gpio2: memory-mapped GPIO block with DIR/OUT/IN registers and
// optional edge-triggered interrupts.
// Build option: define GPIO2_IRQ_EN to include MASK, EDGE and PEND and the
// irq output. Without GPIO2_IRQ_EN those registers are absent, their
// addresses read 0, and irq is tied low.
// All state changes on the falling edge of clk. rst is synchronous and
// active-high.
module mod_gpio2 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ie,
  input  logic             de,
  input  logic [31:0]      iaddr,
  input  logic [31:0]      daddr,
  input  logic             drw,
  input  logic [31:0]      din,
  output logic [31:0]      iout,
  output logic [31:0]      dout,
  inout  wire  [WIDTH-1:0] gpio,
  output logic             irq
);

  localparam logic [31:0] ADDR_DIR  = 32'h0000_0000;
  localparam logic [31:0] ADDR_OUT  = 32'h0000_0004;
  localparam logic [31:0] ADDR_IN   = 32'h0000_0008;
  localparam logic [31:0] ADDR_MASK = 32'h0000_000C;
  localparam logic [31:0] ADDR_EDGE = 32'h0000_0010;
  localparam logic [31:0] ADDR_PEND = 32'h0000_0014;

  logic [WIDTH-1:0] r_dir;
  logic [WIDTH-1:0] r_out;
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  logic             w_wr;
  logic [WIDTH-1:0] w_wdata;
  logic [31:0]      w_rdata;
  logic             w_unused;

  // A write needs the data bus selected, the strobe, and no reset.
  assign w_wr    = de & drw & ~rst;
  assign w_wdata = din[WIDTH-1:0];

  // The instruction port never returns data, so its address is ignored;
  // din bits above WIDTH are likewise discarded.
  assign w_unused = ^{iaddr, din};

  // Tri-state pin drivers: a pin drives OUT only when its DIR bit is set.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_pin
      assign gpio[gi] = r_dir[gi] ? r_out[gi] : 1'bz;
    end
  endgenerate

  // Direction and output data registers.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_dir <= '0;
      r_out <= '0;
    end else if (w_wr) begin
      if (daddr == ADDR_DIR) r_dir <= w_wdata;
      if (daddr == ADDR_OUT) r_out <= w_wdata;
    end
  end

  // Two-stage synchroniser; r_s2 is the value seen as IN. The pin itself is
  // sampled, so driven outputs are observed too.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= gpio;
      r_s2 <= r_s1;
    end
  end

`ifdef GPIO2_IRQ_EN
  logic [WIDTH-1:0] r_h;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge;
  logic [WIDTH-1:0] r_pend;
  logic [WIDTH-1:0] w_hit;
  logic [WIDTH-1:0] w_clr;

  // Per-pin qualifying edge: rising when EDGE=0, falling when EDGE=1,
  // and only for pins whose interrupt is enabled.
  assign w_hit = ((~r_edge & r_s2 & ~r_h) | (r_edge & ~r_s2 & r_h)) & r_mask;
  assign w_clr = (w_wr && (daddr == ADDR_PEND)) ? w_wdata : '0;

  // Edge history, interrupt configuration and pending bits. A new edge is
  // OR-ed in after the clear so that a set beats a simultaneous W1C.
  always_ff @(negedge clk) begin
    if (rst) begin
      r_h    <= '0;
      r_mask <= '0;
      r_edge <= '0;
      r_pend <= '0;
    end else begin
      r_h    <= r_s2;
      r_pend <= (r_pend & ~w_clr) | w_hit;
      if (w_wr && (daddr == ADDR_MASK)) r_mask <= w_wdata;
      if (w_wr && (daddr == ADDR_EDGE)) r_edge <= w_wdata;
    end
  end

  // Level interrupt; masking a bit hides it without losing the pending state.
  assign irq = |(r_pend & r_mask);
`else
  assign irq = 1'b0;
`endif

  // Combinational register read, zero-extended to 32 bits.
  always_comb begin
    w_rdata = '0;
    case (daddr)
      ADDR_DIR:  w_rdata[WIDTH-1:0] = r_dir;
      ADDR_OUT:  w_rdata[WIDTH-1:0] = r_out;
      ADDR_IN:   w_rdata[WIDTH-1:0] = r_s2;
`ifdef GPIO2_IRQ_EN
      ADDR_MASK: w_rdata[WIDTH-1:0] = r_mask;
      ADDR_EDGE: w_rdata[WIDTH-1:0] = r_edge;
      ADDR_PEND: w_rdata[WIDTH-1:0] = r_pend;
`endif
      default:   w_rdata = '0;
    endcase
  end

  // Bus outputs float when their port is not selected.
  assign dout = de ? w_rdata : 32'bz;
  assign iout = ie ? 32'h0 : 32'bz;

endmodule

// File: tb/tb_mod_gpio2.sv
// tb_mod_gpio2: directed table, hand-written corner sequences and randomized
// traffic against a sample-history reference model of mod_gpio2.
module tb_mod_gpio2;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        ie;
  logic        de;
  logic [31:0] iaddr;
  logic [31:0] daddr;
  logic        drw;
  logic [31:0] din;
  wire  [31:0] iout;
  wire  [31:0] dout;
  wire  [W-1:0] gpio;
  wire         irq;

  logic [W-1:0] ext_val;

  int n_checks = 0;
  int n_errors = 0;

  mod_gpio2 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .ie    (ie),
    .de    (de),
    .iaddr (iaddr),
    .daddr (daddr),
    .drw   (drw),
    .din   (din),
    .iout  (iout),
    .dout  (dout),
    .gpio  (gpio),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Register file plus the pin value sampled at the last three falling edges
  // (m_hist0 = most recent). IN shows the sample from one edge back; a pend
  // bit sets when the pin differed between the samples two and three edges back.
  logic [W-1:0] m_dir, m_out, m_mask, m_edge, m_pend;
  logic [W-1:0] m_hist0, m_hist1, m_hist2;
  logic [W-1:0] m_pins, m_set, m_clr;
  logic         m_irq;

  assign m_pins = (m_dir & m_out) | (~m_dir & ext_val);
  assign m_irq  = |(m_pend & m_mask);

  always_comb begin
    m_set = '0;
    for (int n = 0; n < W; n++) begin
      if (m_mask[n] && (m_hist1[n] != m_hist2[n]) && (m_hist1[n] == ~m_edge[n]))
        m_set[n] = 1'b1;
    end
  end

  always_comb begin
    m_clr = '0;
`ifdef GPIO2_IRQ_EN
    if (de && drw && daddr == 32'h14) m_clr = din[W-1:0];
`endif
  end

  always @(negedge clk) begin
    if (rst) begin
      m_dir <= '0; m_out <= '0; m_mask <= '0; m_edge <= '0; m_pend <= '0;
      m_hist0 <= '0; m_hist1 <= '0; m_hist2 <= '0;
    end else begin
      m_hist0 <= m_pins;
      m_hist1 <= m_hist0;
      m_hist2 <= m_hist1;
      m_pend  <= (m_pend & ~m_clr) | m_set;
      if (de && drw) begin
        if (daddr == 32'h00) m_dir <= din[W-1:0];
        if (daddr == 32'h04) m_out <= din[W-1:0];
`ifdef GPIO2_IRQ_EN
        if (daddr == 32'h0C) m_mask <= din[W-1:0];
        if (daddr == 32'h10) m_edge <= din[W-1:0];
`endif
      end
    end
  end

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      32'h00: v[W-1:0] = m_dir;
      32'h04: v[W-1:0] = m_out;
      32'h08: v[W-1:0] = m_hist1;
      32'h0C: v[W-1:0] = m_mask;
      32'h10: v[W-1:0] = m_edge;
      32'h14: v[W-1:0] = m_pend;
      default: v = '0;
    endcase
    return v;
  endfunction

  // External drivers only on pins the model says are inputs.
  for (genvar i = 0; i < W; i++) begin : g_ext
    assign gpio[i] = m_dir[i] ? 1'bz : ext_val[i];
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance one falling edge; return just after the following rising edge.
  task automatic step();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    de = 1'b1; drw = 1'b1; daddr = a; din = d;
    step();
    de = 1'b0; drw = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] v);
    de = 1'b1; drw = 1'b0; daddr = a;
    #1;
    v = dout;
    de = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  logic [31:0] v;
  logic [31:0] irq_exp_c;

  initial begin
`ifdef GPIO2_IRQ_EN
    irq_exp_c = 32'hFFFF;
`else
    irq_exp_c = 32'h0;
`endif
    tbl[0] = '{32'h00,  32'h0000_00FF, 32'h00,  32'h0000_00FF};
    tbl[1] = '{32'h04,  32'hFFFF_00A5, 32'h04,  32'h0000_00A5};
    tbl[2] = '{32'h104, 32'h0000_5555, 32'h04,  32'h0000_00A5};
    tbl[3] = '{32'h104, 32'h0000_5555, 32'h104, 32'h0000_0000};
    tbl[4] = '{32'h18,  32'h0000_FFFF, 32'h18,  32'h0000_0000};
    tbl[5] = '{32'h08,  32'h0000_FFFF, 32'h00,  32'h0000_00FF};
    tbl[6] = '{32'h0C,  32'h0000_FFFF, 32'h0C,  irq_exp_c};
    tbl[7] = '{32'h10,  32'h0000_0003, 32'h10,  irq_exp_c & 32'h3};

    rst = 1'b1; ie = 1'b0; de = 1'b0; drw = 1'b0;
    iaddr = '0; daddr = '0; din = '0;
    ext_val = 16'h3C5A;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;

    // Reset state: all registers read 0, no irq, pins undriven by the DUT.
    check("reset_irq", {31'b0, irq}, 32'h0);
    for (int a = 0; a <= 32'h18; a += 4) begin
      rd(a, v);
      check($sformatf("reset_rd_%0h", a), v, 32'h0);
    end
    check("reset_pins_z", {16'b0, gpio}, {16'b0, ext_val});
    ext_val = '0;
    step(); step(); step();
`ifdef GPIO2_IRQ_EN
    rd(32'h14, v);
    check("held_high_no_pend", v, 32'h0);
`endif

    // Register table: write then read back.
    for (int i = 0; i < 8; i++) begin
      wr(tbl[i].waddr, tbl[i].wdata);
      rd(tbl[i].raddr, v);
      check($sformatf("tbl_%0d", i), v, tbl[i].exp);
    end

    // Low byte driven by the DUT, upper byte by the bench.
    ext_val = 16'hC300;
    #1;
    check("drive_a5", {16'b0, gpio}, 32'h0000_C3A5);
    ie = 1'b1; iaddr = 32'h0;
    #1;
    check("iout_zero", iout, 32'h0);
    ie = 1'b0;

    // Synchroniser latency: visible after the second edge, not the first.
    do_reset();
    ext_val = 16'h1234;
    step();
    rd(32'h08, v);
    check("in_edge1", v, 32'h0);
    step();
    rd(32'h08, v);
    check("in_edge2", v, 32'h1234);

    // Reset beats a simultaneous write.
    wr(32'h00, 32'hFFFF);
    rst = 1'b1; de = 1'b1; drw = 1'b1; daddr = 32'h04; din = 32'hFFFF;
    step();
    rst = 1'b0; de = 1'b0; drw = 1'b0;
    rd(32'h04, v);
    check("rst_vs_wr_out", v, 32'h0);
    rd(32'h00, v);
    check("rst_vs_wr_dir", v, 32'h0);
    ext_val = 16'h0F0F;
    #1;
    check("rst_vs_wr_pins_z", {16'b0, gpio}, 32'h0000_0F0F);

`ifdef GPIO2_IRQ_EN
    // Rising edge on pin0 sets PEND at edge k+2, W1C clears it.
    ext_val = '0;
    do_reset();
    wr(32'h0C, 32'h1);
    wr(32'h10, 32'h0);
    step(); step(); step();
    ext_val = 16'h0001;
    step();
    check("rise_k", {31'b0, irq}, 32'h0);
    step();
    check("rise_k1", {31'b0, irq}, 32'h0);
    step();
    rd(32'h14, v);
    check("rise_k2_pend", v, 32'h1);
    check("rise_k2_irq", {31'b0, irq}, 32'h1);
    wr(32'h14, 32'h1);
    check("w1c_irq", {31'b0, irq}, 32'h0);

    // Masking hides irq but keeps PEND.
    ext_val = '0;
    step(); step(); step();
    ext_val = 16'h0001;
    step(); step(); step();
    check("remask_irq", {31'b0, irq}, 32'h1);
    wr(32'h0C, 32'h0);
    check("mask_off_irq", {31'b0, irq}, 32'h0);
    rd(32'h14, v);
    check("mask_off_pend", v, 32'h1);

    // Falling-edge set collides with W1C: set wins.
    ext_val = '0;
    do_reset();
    wr(32'h10, 32'h2);
    wr(32'h0C, 32'h2);
    ext_val = 16'h0002;
    step(); step(); step();
    rd(32'h14, v);
    check("fall_mode_rise_ignored", v, 32'h0);
    ext_val = '0;
    step(); step(); step();
    rd(32'h14, v);
    check("fall_sets", v, 32'h2);
    ext_val = 16'h0002;
    step(); step(); step();
    ext_val = '0;
    step();
    step();
    wr(32'h14, 32'h2);
    rd(32'h14, v);
    check("set_beats_clr", v, 32'h2);
    check("set_beats_clr_irq", {31'b0, irq}, 32'h1);
    wr(32'h14, 32'h2);
    rd(32'h14, v);
    check("plain_clr", v, 32'h0);

    // Edge on a DUT-driven pin is still detected.
    do_reset();
    wr(32'h0C, 32'h1);
    wr(32'h00, 32'h1);
    wr(32'h04, 32'h1);
    step(); step(); step();
    rd(32'h14, v);
    check("output_pin_edge", v, 32'h1);
`else
    // Interrupt registers absent: MASK reads 0, irq never rises.
    do_reset();
    wr(32'h0C, 32'hFFFF);
    for (int i = 0; i < 6; i++) begin
      ext_val = (i % 2 == 0) ? 16'hFFFF : 16'h0000;
      step();
      check($sformatf("noirq_irq_%0d", i), {31'b0, irq}, 32'h0);
    end
    rd(32'h0C, v);
    check("noirq_mask_rd", v, 32'h0);
`endif

    // Randomized traffic against the model.
    ext_val = '0;
    do_reset();
    for (int it = 0; it < 400; it++) begin
      rst   = ($urandom_range(0, 49) == 0);
      de    = ($urandom_range(0, 3) != 0);
      drw   = $urandom_range(0, 1);
      daddr = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 7) * 4);
      din   = $urandom();
      if ($urandom_range(0, 3) == 0) ext_val = W'($urandom());
      #1;
      if (de) check($sformatf("rnd_dout_%0d", it), dout, m_read(daddr));
      check($sformatf("rnd_irq_%0d", it), {31'b0, irq}, {31'b0, m_irq});
      check($sformatf("rnd_pins_%0d", it), {16'b0, gpio}, {16'b0, m_pins});
      step();
    end
    rst = 1'b0; de = 1'b0; drw = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
